// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage: datapath width, fixed encodings
// and the fetch controller state type.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    localparam logic [31:0] RV_ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        HALT
    } fetch_state_t;
endpackage

// File: rtl/adder.sv
// Plain W-bit adder; the carry out is dropped, so sums wrap modulo 2^W.
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);
    assign o_y = i_a + i_b;
endmodule

// File: rtl/edge_rise.sv
// Rising-edge detector for a level input (e.g. a debounced push-button).
// History is cleared by the synchronous active-low reset.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise
);
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads a 1-cycle-latency imem and hands one
// instruction at a time to execute. Supports free-run and single-step.
module instr_fetch
    import rv_pkg::fetch_state_t, rv_pkg::IDLE, rv_pkg::FETCH, rv_pkg::HOLD,
           rv_pkg::HALT, rv_pkg::RV_NOP, rv_pkg::RV_ECALL;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int IMEM_AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    instr,
    output logic [XLEN-1:0]    pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               halted,
    output logic               misalign,
    output logic [31:0]        retired,
    output logic [1:0]         dbg_state
);
    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;
    logic            r_halted;
    logic            r_misalign;
    logic [31:0]     r_retired;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_target;
    logic [XLEN-1:0] w_pc_look;
    logic            w_step_rise;
    logic            w_accept;
    logic            w_is_ecall;
    logic            w_bad_target;
    logic            w_stop;

    edge_rise u_step_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (step),
        .o_rise (w_step_rise)
    );

    adder #(.W(XLEN)) u_pc_inc (
        .i_a (r_pc),
        .i_b (XLEN'(4)),
        .o_y (w_pc_plus4)
    );

    // Handshake: a transfer happens on a cycle where instr_valid and instr_ready
    // are both high; once raised, instr_valid/instr/pc stay put until that transfer.
    assign w_accept     = r_valid & instr_ready;
    assign w_is_ecall   = (r_instr == XLEN'(RV_ECALL));
    assign w_bad_target = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign w_stop       = w_is_ecall | w_bad_target;
    assign w_pc_target  = redirect_valid ? redirect_pc : w_pc_plus4;

    // imem is addressed with the PC the register will hold after this edge, so a
    // FETCH that directly follows an accept sees the new word, not the old one.
    assign w_pc_look = (w_accept & ~w_stop) ? w_pc_target : r_pc;
    assign imem_addr = w_pc_look[IMEM_AW+1:2];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (run | w_step_rise) w_state_next = FETCH;
            FETCH:   w_state_next = HOLD;
            HOLD: begin
                if (w_accept) begin
                    if (w_stop)   w_state_next = HALT;
                    else if (run) w_state_next = FETCH;
                    else          w_state_next = IDLE;
                end
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= XLEN'(RV_NOP);
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
            r_retired  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_look;
            if (r_state == FETCH) begin
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_accept) begin
                r_valid   <= 1'b0;
                r_retired <= r_retired + 32'd1;
                if (w_stop) r_halted <= 1'b1;
                // An ECALL halt takes priority, so misalign only flags a real redirect fault.
                if (~w_is_ecall & w_bad_target) r_misalign <= 1'b1;
            end
        end
    end

    assign instr       = r_instr;
    assign pc          = r_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign misalign    = r_misalign;
    assign retired     = r_retired;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized run/step/
// ready/redirect traffic, all compared against a cycle-level reference model.
module tb_instr_fetch;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        run;
    logic        step;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        halted;
    logic        misalign;
    logic [31:0] retired;
    logic [1:0]  dbg_state;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .step           (step),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .pc             (pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .misalign       (misalign),
        .retired        (retired),
        .dbg_state      (dbg_state)
    );

    // synchronous instruction memory, one cycle of read latency
    logic [31:0] mem [64];
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 waiting, 1 reading memory, 2 presenting, 3 stopped.
    int          m_phase = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = NOP;
    logic        m_valid = 1'b0;
    logic        m_halt = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_ret = 32'h0;
    logic        m_step_prev = 1'b0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[(a / 4) % 64];
    endfunction

    function automatic logic [5:0] exp_addr();
        logic [31:0] nxt;
        nxt = m_pc;
        if (m_phase == 2 && instr_ready && m_instr != ECALL &&
            !(redirect_valid && redirect_pc % 4 != 0))
            nxt = redirect_valid ? redirect_pc : m_pc + 32'd4;
        return 6'((nxt / 4) % 64);
    endfunction

    task automatic model_edge();
        logic step_edge;
        if (!reset) begin
            m_phase = 0; m_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
            m_halt = 1'b0; m_mis = 1'b0; m_ret = 32'h0; m_step_prev = 1'b0;
        end else begin
            step_edge = step && !m_step_prev;
            m_step_prev = step;
            case (m_phase)
                0: if (run || step_edge) m_phase = 1;
                1: begin
                    m_instr = word_at(m_pc);
                    m_valid = 1'b1;
                    m_phase = 2;
                end
                2: if (instr_ready) begin
                    m_valid = 1'b0;
                    m_ret = m_ret + 1;
                    if (m_instr == ECALL) begin
                        m_halt = 1'b1; m_phase = 3;
                    end else if (redirect_valid && redirect_pc % 4 != 0) begin
                        m_halt = 1'b1; m_mis = 1'b1; m_phase = 3;
                    end else begin
                        m_pc = redirect_valid ? redirect_pc : m_pc + 32'd4;
                        m_phase = run ? 1 : 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // driver: inputs are set at the falling edge before calling tick
    task automatic tick();
        #1;
        check("imem_addr", {26'b0, imem_addr}, {26'b0, exp_addr()});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("pc", pc, m_pc);
        check("instr", instr, m_instr);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("halted", {31'b0, halted}, {31'b0, m_halt});
        check("misalign", {31'b0, misalign}, {31'b0, m_mis});
        check("retired", retired, m_ret);
    endtask

    function automatic logic [31:0] rand_word(input int ecall_in_16);
        logic [31:0] w;
        w = $urandom;
        if (w == ECALL) w = w ^ 32'h100;
        if (ecall_in_16 > 0 && $urandom_range(0, 15) < ecall_in_16) w = ECALL;
        return w;
    endfunction

    task automatic load_mem(input int ecall_in_16);
        for (int i = 0; i < 64; i++) mem[i] = rand_word(ecall_in_16);
        mem[0] = 32'h0020_81b3;
        mem[1] = 32'h0031_0233;
        mem[2] = 32'h0041_82b3;
        mem[3] = 32'h0052_0333;
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; step = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; step = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        load_mem(0);
        @(negedge clk);

        // 1: reset then idle
        tick(); tick();
        reset = 1'b1;
        repeat (4) tick();
        check("t1_instr", instr, NOP);
        check("t1_valid", {31'b0, instr_valid}, 32'h0);

        // 2: free run, ready tied high
        run = 1'b1; instr_ready = 1'b1;
        repeat (9) tick();
        check("t2_retired", retired, 32'd4);
        check("t2_pc", pc, 32'd16);
        run = 1'b0;
        tick(); tick();
        check("t2_stop_retired", retired, 32'd5);
        check("t2_stop_valid", {31'b0, instr_valid}, 32'h0);

        // 3: single step with the button held
        do_reset();
        step = 1'b1; instr_ready = 1'b1;
        repeat (5) tick();
        check("t3_one_retired", retired, 32'd1);
        check("t3_pc", pc, 32'd4);
        step = 1'b0; instr_ready = 1'b0; tick();
        step = 1'b1; tick(); tick();
        check("t3_second_pc", pc, 32'd4);
        check("t3_second_valid", {31'b0, instr_valid}, 32'h1);

        // 4: stall while valid
        step = 1'b0;
        repeat (3) tick();
        check("t4_hold_pc", pc, 32'd4);
        check("t4_hold_instr", instr, 32'h0031_0233);
        instr_ready = 1'b1; tick();
        check("t4_adv_pc", pc, 32'd8);

        // 5: redirects, PC wrap, misaligned target
        run = 1'b1; instr_ready = 1'b0;
        tick(); tick();
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20; tick();
        check("t5_redir_pc", pc, 32'h20);
        check("t5_redir_addr", {26'b0, imem_addr}, 32'd8);
        redirect_valid = 1'b0; instr_ready = 1'b0; tick();
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
        redirect_valid = 1'b0; instr_ready = 1'b0; tick();
        instr_ready = 1'b1; tick();
        check("t5_wrap_pc", pc, 32'h0);
        instr_ready = 1'b0; tick();
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h22; tick();
        check("t5_misalign", {31'b0, misalign}, 32'h1);
        check("t5_halted", {31'b0, halted}, 32'h1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step = i[0]; tick();
        end

        // 6: ECALL halts, then reset from mid-HOLD
        mem[2] = ECALL;
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        repeat (7) tick();
        for (int i = 0; i < 8; i++) begin
            step = i[0]; run = i[1]; tick();
        end
        check("t6_halted", {31'b0, halted}, 32'h1);
        check("t6_pc", pc, 32'd8);
        check("t6_retired", retired, 32'd3);
        do_reset();
        run = 1'b1; instr_ready = 1'b0;
        tick(); tick();
        reset = 1'b0; tick();
        check("t6_rst_pc", pc, 32'h0);
        check("t6_rst_instr", instr, NOP);
        check("t6_rst_valid", {31'b0, instr_valid}, 32'h0);
        check("t6_rst_halted", {31'b0, halted}, 32'h0);
        reset = 1'b1;

        // randomized traffic
        load_mem(1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                load_mem(1);
            end else begin
                reset = 1'b1;
            end
            run = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) step = ~step;
            instr_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 4) == 0);
            redirect_pc = $urandom;
            if ($urandom_range(0, 15) != 0) redirect_pc[1:0] = 2'b00;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
